// File: rtl/regfile_write_buffer.sv
// In-order write-request queue in front of the register file write port.
// Buffers (reg, data) writes, drains one per cycle when the register file
// accepts, and offers two combinational forwarding lookups over queued writes.
module regfile_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    output logic                     wr_en,
    output logic [4:0]               wr_reg,
    output logic [31:0]              wr_data,
    input  logic                     wr_ready,
    input  logic [4:0]               lookup_regA,
    input  logic [4:0]               lookup_regB,
    output logic                     lookup_hitA,
    output logic                     lookup_hitB,
    output logic [31:0]              lookup_dataA,
    output logic [31:0]              lookup_dataB,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [4:0]       ent_reg_d  [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q;
    logic             wr_en_q;
    logic [4:0]       wr_reg_q;
    logic [31:0]      wr_data_q;
    logic             enq_store;
    logic             deq;

    // Scan stored entries oldest to youngest so the youngest match wins.
    function automatic logic [32:0] forward(input logic [4:0] r);
        logic [32:0]      res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (ent_reg_q[idx] == r) && (r != 5'd0)) begin
                res = {1'b1, ent_data_q[idx]};
            end
        end
        return res;
    endfunction

    // Next-state: store non-zero-register enqueues at tail, pop head on drain.
    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        enq_store  = in_valid && in_ready_q && (in_reg != 5'd0);
        deq        = wr_en_q && wr_ready;
        if (enq_store) begin
            ent_reg_d[tail_q]  = in_reg;
            ent_data_d[tail_q] = in_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq_store && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq_store && deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State and registered outputs; reset overrides any handshake.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < FULL);
            wr_en_q    <= (count_d != '0);
            wr_reg_q   <= (count_d != '0) ? ent_reg_d[head_d]  : 5'd0;
            wr_data_q  <= (count_d != '0) ? ent_data_d[head_d] : 32'd0;
        end
    end

    // Forwarding lookups for read ports A and B.
    always_comb begin
        {lookup_hitA, lookup_dataA} = forward(lookup_regA);
        {lookup_hitB, lookup_dataB} = forward(lookup_regB);
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [4:0]  lookup_regA;
    logic [4:0]  lookup_regB;
    logic        lookup_hitA;
    logic        lookup_hitB;
    logic [31:0] lookup_dataA;
    logic [31:0] lookup_dataB;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_ready(wr_ready),
        .lookup_regA(lookup_regA), .lookup_regB(lookup_regB),
        .lookup_hitA(lookup_hitA), .lookup_hitB(lookup_hitB),
        .lookup_dataA(lookup_dataA), .lookup_dataB(lookup_dataB),
        .count(count)
    );

    always #5 clock = ~clock;

    // Advance one clock edge, updating the reference queue from the inputs at that edge.
    task automatic step();
        logic acc;
        logic dq;
        ent_t e;
        acc = in_valid && (mq.size() < DEPTH);
        dq  = (mq.size() != 0) && wr_ready;
        e.r = in_reg;
        e.d = in_data;
        @(posedge clock);
        if (ctrl_reset) begin
            mq.delete();
        end else begin
            if (dq) void'(mq.pop_front());
            if (acc && e.r != 5'd0) mq.push_back(e);
        end
        #1;
    endtask

    // Youngest queued write to register r, from the reference queue.
    function automatic void model_lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (r == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == r) begin
                hit = 1'b1;
                d   = mq[i].d;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        ctrl_reset = 1'b1;
        in_valid   = 1'b0;
        wr_ready   = 1'b0;
        step();
        ctrl_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lookup_regA = 5'd5;
        #1;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'd0) begin
            errors++; $display("FAIL reset_wr got=%b/%0d/%h exp=0/0/0", wr_en, wr_reg, wr_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (lookup_hitA !== 1'b0 || lookup_dataA !== 32'd0) begin
            errors++; $display("FAIL reset_lookup got=%b/%h exp=0/0", lookup_hitA, lookup_dataA);
        end
    endtask

    task automatic test_fill_stall();
        logic [4:0]  regs [4] = '{5'd3, 5'd7, 5'd3, 5'd9};
        logic [31:0] dats [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = regs[i]; in_data = dats[i];
            step();
        end
        in_reg = 5'd11; in_data = 32'hE;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got count=%0d rdy=%b exp 4/0", count, in_ready);
        end
        step();
        in_valid = 1'b0;
        lookup_regA = 5'd3; lookup_regB = 5'd7;
        #1;
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_held got=%0d exp=4", count); end
        checks++;
        if (lookup_hitA !== 1'b1 || lookup_dataA !== 32'hC) begin
            errors++; $display("FAIL fill_fwdA got=%b/%h exp=1/c", lookup_hitA, lookup_dataA);
        end
        checks++;
        if (lookup_hitB !== 1'b1 || lookup_dataB !== 32'hB) begin
            errors++; $display("FAIL fill_fwdB got=%b/%h exp=1/b", lookup_hitB, lookup_dataB);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'hA) begin
            errors++; $display("FAIL fill_head got=%b/%0d/%h exp=1/3/a", wr_en, wr_reg, wr_data);
        end
    endtask

    task automatic test_drain();
        logic [4:0]  regs [4] = '{5'd3, 5'd7, 5'd3, 5'd9};
        logic [31:0] dats [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        in_valid = 1'b0;
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_en !== 1'b1 || wr_reg !== regs[k] || wr_data !== dats[k]) begin
                errors++;
                $display("FAIL drain_%0d got=%b/%0d/%h exp=1/%0d/%h", k, wr_en, wr_reg, wr_data, regs[k], dats[k]);
            end
            step();
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
            end
        end
        checks++;
        if (wr_en !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL drain_empty got=%b/%0d exp=0/0", wr_en, count);
        end
    endtask

    task automatic test_stream_wrap();
        wr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_reg = 5'(i + 1); in_data = 32'h100 + 32'(i);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_reg !== 5'(i + 1) || wr_data !== 32'h100 + 32'(i) || count !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d got=%b/%0d/%h cnt=%0d exp=1/%0d/%h cnt=1",
                         i, wr_en, wr_reg, wr_data, count, i + 1, 32'h100 + 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (count !== 3'd0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL stream_end got=%0d/%b exp=0/0", count, wr_en);
        end
    endtask

    task automatic test_reg0_filter();
        wr_ready = 1'b0;
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        lookup_regB = 5'd0;
        #1;
        checks++;
        if (count !== 3'd0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL reg0_stored got=%0d/%b exp=0/0", count, wr_en);
        end
        checks++;
        if (lookup_hitB !== 1'b0 || lookup_dataB !== 32'd0) begin
            errors++; $display("FAIL reg0_lookup got=%b/%h exp=0/0", lookup_hitB, lookup_dataB);
        end
    endtask

    task automatic test_forward_timing();
        wr_ready = 1'b0;
        in_valid = 1'b1; in_reg = 5'd12; in_data = 32'h1234;
        lookup_regA = 5'd12;
        #1;
        checks++;
        if (lookup_hitA !== 1'b0) begin errors++; $display("FAIL fwd_inflight got=%b exp=0", lookup_hitA); end
        step();
        in_valid = 1'b0;
        wr_ready = 1'b1;
        #1;
        checks++;
        if (lookup_hitA !== 1'b1 || lookup_dataA !== 32'h1234) begin
            errors++; $display("FAIL fwd_dequeuing got=%b/%h exp=1/1234", lookup_hitA, lookup_dataA);
        end
        step();
        checks++;
        if (lookup_hitA !== 1'b0 || lookup_dataA !== 32'd0) begin
            errors++; $display("FAIL fwd_gone got=%b/%h exp=0/0", lookup_hitA, lookup_dataA);
        end
    endtask

    task automatic test_reset_mid();
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_reg = 5'(4 + i); in_data = 32'h50 + 32'(i);
            step();
        end
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL rmid_pre got=%0d exp=3", count); end
        ctrl_reset = 1'b1; in_valid = 1'b1; in_reg = 5'd8; in_data = 32'h88; wr_ready = 1'b1;
        step();
        ctrl_reset = 1'b0; in_valid = 1'b0;
        lookup_regA = 5'd4; lookup_regB = 5'd8;
        #1;
        checks++;
        if (count !== 3'd0 || wr_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_state got=%0d/%b/%b exp=0/0/1", count, wr_en, in_ready);
        end
        checks++;
        if (lookup_hitA !== 1'b0 || lookup_hitB !== 1'b0) begin
            errors++; $display("FAIL rmid_lookup got=%b/%b exp=0/0", lookup_hitA, lookup_hitB);
        end
    endtask

    task automatic test_random();
        logic        eh_a, eh_b;
        logic [31:0] ed_a, ed_b;
        logic [4:0]  er;
        logic [31:0] ed;
        mq.delete();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ctrl_reset  = ($urandom_range(0, 49) == 0);
            in_valid    = ($urandom_range(0, 99) < 65);
            in_reg      = 5'($urandom_range(0, 7));
            in_data     = $urandom;
            wr_ready    = ($urandom_range(0, 99) < 45);
            lookup_regA = 5'($urandom_range(0, 7));
            lookup_regB = 5'($urandom_range(0, 7));
            #1;
            model_lookup(lookup_regA, eh_a, ed_a);
            model_lookup(lookup_regB, eh_b, ed_b);
            checks++;
            if (lookup_hitA !== eh_a || lookup_dataA !== ed_a || lookup_hitB !== eh_b || lookup_dataB !== ed_b) begin
                errors++;
                $display("FAIL rand_lookup_%0d got A=%b/%h B=%b/%h exp A=%b/%h B=%b/%h",
                         n, lookup_hitA, lookup_dataA, lookup_hitB, lookup_dataB, eh_a, ed_a, eh_b, ed_b);
            end
            step();
            er = (mq.size() != 0) ? mq[0].r : 5'd0;
            ed = (mq.size() != 0) ? mq[0].d : 32'd0;
            checks++;
            if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH) ||
                wr_en !== (mq.size() != 0) || wr_reg !== er || wr_data !== ed) begin
                errors++;
                $display("FAIL rand_state_%0d got cnt=%0d rdy=%b wr=%b/%0d/%h exp cnt=%0d wr=%0d/%h",
                         n, count, in_ready, wr_en, wr_reg, wr_data, mq.size(), er, ed);
            end
        end
        ctrl_reset = 1'b0;
        in_valid   = 1'b0;
    endtask

    initial begin
        ctrl_reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
        wr_ready = 1'b0; lookup_regA = '0; lookup_regB = '0;
        test_reset();
        test_fill_stall();
        test_drain();
        test_stream_wrap();
        test_reg0_filter();
        test_forward_timing();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
